// File: rtl/switch_led_pkg.sv
// rtl/switch_led_pkg.sv - shared constants and helpers for the switch/LED controller
// Purpose: default channel count and debounce limits, plus the debounce
//          counter width helper used by debounce_filter.
// Ports:   none (package).
package switch_led_pkg;

  localparam int NUM_CH_DEF         = 4;
  localparam int DEBOUNCE_LIMIT_DEF = 250000;   // 10 ms at 25 MHz
  localparam int DEBOUNCE_LIMIT_SIM = 4;        // short window for simulation

  // Counter must hold 0..limit-1; a limit of 1 still needs a 1-bit counter.
  function automatic int cnt_width(input int limit);
    int w;
    w = $clog2(limit);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/switch_led_ctrl_if.sv
// rtl/switch_led_ctrl_if.sv - switch/LED signal bundle for the controller
// Purpose: groups the switch inputs, clear strobe and LED/press outputs.
// Ports (signals):
//   sw    - raw switch levels, 1 = pressed
//   clear - clear toggle-mode LED states
//   led   - LED drive, 1 = on
//   press - one-cycle pulse per accepted press
// Modports: master drives sw/clear and observes led/press; slave is the
//           controller side.
interface switch_led_ctrl_if #(
  parameter int NUM_CH = 4
);

  logic [NUM_CH-1:0] sw;
  logic              clear;
  logic [NUM_CH-1:0] led;
  logic [NUM_CH-1:0] press;

  modport master (
    output sw,
    output clear,
    input  led,
    input  press
  );

  modport slave (
    input  sw,
    input  clear,
    output led,
    output press
  );

endinterface

// File: rtl/debounce_filter.sv
// rtl/debounce_filter.sv - single-channel synchronizer and debounce filter
// Purpose: brings one raw switch into the clock domain through two flops and
//          accepts a new level only after it has differed from the accepted
//          level for DEBOUNCE_LIMIT consecutive edges.
// Ports:
//   i_Clk    - system clock, rising edge
//   i_Reset  - asynchronous active-high reset
//   i_Switch - raw, bouncing switch level
//   o_Switch - debounced level
module debounce_filter
  import switch_led_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEF
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Switch,
  output logic o_Switch
);

  localparam int            CW       = cnt_width(DEBOUNCE_LIMIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_LIMIT - 1);

  logic          meta_q;
  logic          sync_q;
  logic          state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any return to the accepted level restarts the window; the counter stops
  // at CNT_LAST because the level is accepted there, so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (sync_q == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      state_d = sync_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= i_Switch;
      sync_q  <= meta_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_Switch = state_q;

endmodule

// File: rtl/switch_led_ctrl.sv
// rtl/switch_led_ctrl.sv - debounced multi-channel switch to LED controller
// Purpose: debounces NUM_CH switches, pulses o_Press on each accepted press
//          and drives LEDs either directly from the debounced level or as a
//          press-toggled latch (TOGGLE_MASK bit = 1).
// Ports:
//   i_Clk    - system clock, rising edge
//   i_Reset  - asynchronous active-high reset
//   i_Switch - raw switch levels, 1 = pressed
//   i_Clear  - clears all toggle-mode LEDs on the next edge
//   o_LED    - registered LED drive, 1 = on
//   o_Press  - registered one-cycle pulse per accepted press
module switch_led_ctrl
  import switch_led_pkg::*;
#(
  parameter int                NUM_CH         = NUM_CH_DEF,
  parameter int                DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEF,
  parameter logic [NUM_CH-1:0] TOGGLE_MASK    = '0
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic [NUM_CH-1:0] i_Switch,
  input  logic              i_Clear,
  output logic [NUM_CH-1:0] o_LED,
  output logic [NUM_CH-1:0] o_Press
);

  logic [NUM_CH-1:0] db;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] d_prev_q, d_prev_d;
  logic [NUM_CH-1:0] press_q, press_d;
  logic [NUM_CH-1:0] led_q, led_d;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    debounce_filter #(
      .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_debounce (
      .i_Clk   (i_Clk),
      .i_Reset (i_Reset),
      .i_Switch(i_Switch[n]),
      .o_Switch(db[n])
    );
  end

  always_comb begin
    rise     = db & ~d_prev_q;
    d_prev_d = db;
    press_d  = rise;
    led_d    = led_q;
    for (int n = 0; n < NUM_CH; n++) begin
      if (TOGGLE_MASK[n]) begin
        // Clear has priority over a press landing on the same edge.
        if (i_Clear) begin
          led_d[n] = 1'b0;
        end else if (rise[n]) begin
          led_d[n] = ~led_q[n];
        end
      end else begin
        led_d[n] = db[n];
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      d_prev_q <= '0;
      press_q  <= '0;
      led_q    <= '0;
    end else begin
      d_prev_q <= d_prev_d;
      press_q  <= press_d;
      led_q    <= led_d;
    end
  end

  assign o_LED   = led_q;
  assign o_Press = press_q;

endmodule

// File: tb/tb_switch_led_ctrl.sv
// tb/tb_switch_led_ctrl.sv - self-checking bench for switch_led_ctrl
module tb_switch_led_ctrl;

  localparam int         NCH  = 4;
  localparam int         L    = 4;
  localparam logic [3:0] TMASK = 4'b1100;

  logic clk;
  logic rst;

  switch_led_ctrl_if #(.NUM_CH(NCH)) ifc ();

  switch_led_ctrl #(
    .NUM_CH        (NCH),
    .DEBOUNCE_LIMIT(L),
    .TOGGLE_MASK   (TMASK)
  ) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .i_Switch(ifc.sw),
    .i_Clear (ifc.clear),
    .o_LED   (ifc.led),
    .o_Press (ifc.press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int p2_cnt   = 0;
  int p2_start = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the synchronizer is a 2-edge delay of the raw input;
  // a channel's accepted level flips when the last L synchronized samples all
  // disagree with it. Outputs are the registered consequences of that level.
  logic [3:0] m_pipe0, m_pipe1, m_d, m_dprev, m_led, m_press, m_s, m_nd;
  logic [3:0] m_hist [L];
  bit         m_all;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pipe0 = '0; m_pipe1 = '0; m_d = '0; m_dprev = '0;
      m_led = '0; m_press = '0;
      for (int i = 0; i < L; i++) m_hist[i] = '0;
    end else begin
      m_s = m_pipe1;
      m_pipe1 = m_pipe0;
      m_pipe0 = ifc.sw;
      for (int i = L - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = m_s;
      m_nd = m_d;
      for (int c = 0; c < NCH; c++) begin
        m_all = 1'b1;
        for (int i = 0; i < L; i++) if (m_hist[i][c] == m_d[c]) m_all = 1'b0;
        if (m_all) m_nd[c] = m_s[c];
      end
      m_press = m_d & ~m_dprev;
      for (int c = 0; c < NCH; c++) begin
        if (TMASK[c]) begin
          if (ifc.clear) m_led[c] = 1'b0;
          else if (m_press[c]) m_led[c] = ~m_led[c];
        end else begin
          m_led[c] = m_d[c];
        end
      end
      m_dprev = m_d;
      m_d = m_nd;
    end
  end

  always @(negedge clk) begin
    check("model_led", ifc.led, m_led);
    check("model_press", ifc.press, m_press);
    if (ifc.press[2] === 1'b1) p2_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    ifc.sw = '0;
    ifc.clear = 1'b0;
    tick(2);
    check("reset_led", ifc.led, 4'b0000);
    check("reset_press", ifc.press, 4'b0000);
    rst = 1'b0;
    tick(3);

    // Direct-mode press and release on channel 0
    ifc.sw = 4'b0001;
    tick(6);
    check("t1_led_e6", ifc.led, 4'b0000);
    tick(1);
    check("t1_led_e7", ifc.led, 4'b0001);
    check("t1_press_e7", ifc.press, 4'b0001);
    tick(1);
    check("t1_press_e8", ifc.press, 4'b0000);
    tick(4);
    ifc.sw = 4'b0000;
    tick(6);
    check("t1_rel_led_e6", ifc.led, 4'b0001);
    tick(1);
    check("t1_rel_led_e7", ifc.led, 4'b0000);
    check("t1_rel_press_e7", ifc.press, 4'b0000);
    tick(3);

    // Short glitch must be rejected
    ifc.sw = 4'b0001;
    tick(3);
    ifc.sw = 4'b0000;
    tick(10);
    check("t2_glitch_led", ifc.led, 4'b0000);

    // Toggle channel 2 pressed twice
    p2_start = p2_cnt;
    ifc.sw = 4'b0100; tick(10);
    check("t3_led_on", ifc.led, 4'b0100);
    ifc.sw = 4'b0000; tick(10);
    check("t3_led_hold", ifc.led, 4'b0100);
    ifc.sw = 4'b0100; tick(10);
    check("t3_led_off", ifc.led, 4'b0000);
    ifc.sw = 4'b0000; tick(10);
    check("t3_press_count", 4'(p2_cnt - p2_start), 4'd2);

    // Build 1100, then clear on channel 3's press edge
    ifc.sw = 4'b0100; tick(10);
    ifc.sw = 4'b0000; tick(10);
    ifc.sw = 4'b1000; tick(10);
    ifc.sw = 4'b0000; tick(10);
    check("t4_led_1100", ifc.led, 4'b1100);
    ifc.sw = 4'b1000;
    tick(6);
    ifc.clear = 1'b1;
    tick(1);
    check("t4_clear_led", ifc.led, 4'b0000);
    check("t4_clear_press", ifc.press, 4'b1000);
    ifc.clear = 1'b0;
    tick(1);
    check("t4_led_after", ifc.led, 4'b0000);
    ifc.sw = 4'b0000; tick(10);

    // Reset in the middle of a debounce window
    ifc.sw = 4'b0100; tick(10);
    ifc.sw = 4'b0000; tick(10);
    check("t5_pre_led", ifc.led, 4'b0100);
    ifc.sw = 4'b0001;
    tick(2);
    rst = 1'b1;
    #1;
    check("t5_rst_async_led", ifc.led, 4'b0000);
    tick(2);
    check("t5_rst_led", ifc.led, 4'b0000);
    check("t5_rst_press", ifc.press, 4'b0000);
    rst = 1'b0;
    tick(6);
    check("t5_led_e6", ifc.led, 4'b0000);
    tick(1);
    check("t5_led_e7", ifc.led, 4'b0001);
    check("t5_press_e7", ifc.press, 4'b0001);
    tick(3);

    // All four pressed together
    ifc.sw = 4'b0000; tick(10);
    check("t6_pre_led", ifc.led, 4'b0000);
    ifc.sw = 4'b1111;
    tick(7);
    check("t6_press", ifc.press, 4'b1111);
    check("t6_led", ifc.led, 4'b1111);
    tick(1);
    check("t6_press_end", ifc.press, 4'b0000);
    ifc.sw = 4'b0000; tick(10);
    check("t6_rel_led", ifc.led, 4'b1100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
